// File: rtl/uart_msg_arbiter_if.sv
// uart_msg_arbiter_if: byte streams from the message sources and the byte-accept link to the UART transmitter
interface uart_msg_arbiter_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]   s_valid;
    logic [8*NUM_SRC-1:0] s_data;
    logic [NUM_SRC-1:0]   s_last;
    logic [NUM_SRC-1:0]   s_ready;
    logic                 m_valid;
    logic [7:0]           m_data;
    logic                 m_ready;

    modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: message-locked round-robin arbiter sharing one UART byte sink among NUM_SRC sources
module uart_msg_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    uart_msg_arbiter_if.slave  bus,
    output logic [NUM_SRC-1:0] grant_o,
    output logic               busy_o,
    output logic               len_err_o
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d, win, idx;
    logic [7:0]         cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               len_err_q, len_err_d;
    logic               xfer, hs, at_max, done;

    // the pointer doubles as the index of the current owner while in XFER
    assign xfer        = state_q == XFER;
    assign bus.m_valid = xfer & bus.s_valid[ptr_q];
    assign bus.m_data  = xfer ? bus.s_data[{ptr_q, 3'b000} +: 8] : 8'h00;
    assign bus.s_ready = xfer ? (NUM_SRC'(bus.m_ready) << ptr_q) : '0;
    assign hs          = bus.m_valid & bus.m_ready;
    assign at_max      = cnt_q + 8'd1 == 8'(MAX_PKT_LEN);
    assign done        = hs & (bus.s_last[ptr_q] | at_max);
    assign grant_o     = grant_q;
    assign busy_o      = state_q != IDLE;
    assign len_err_o   = len_err_q;

    // round-robin search: scanning offsets downward leaves the nearest requester after the pointer as winner
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = IW'((int'(ptr_q) + k) % NUM_SRC);
            if (bus.s_valid[idx]) win = idx;
        end
    end

    // message sequencing: grant once per message, count bytes, cut runaways, then hold the idle gap
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        len_err_d = len_err_q | (hs & ~bus.s_last[ptr_q] & at_max);
        if (state_q == IDLE && |bus.s_valid) begin
            state_d = XFER;
            grant_d = NUM_SRC'(1) << win;
            ptr_d   = win;
            cnt_d   = '0;
        end else if (xfer && hs) begin
            cnt_d = cnt_q + 8'd1;
            if (done) begin
                grant_d = '0;
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                gap_d   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
            end
        end else if (state_q == GAP) begin
            gap_d   = gap_q - 1'b1;
            state_d = (gap_q == '0) ? IDLE : GAP;
        end
    end

    // state registers; reset abandons any message in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= IW'(NUM_SRC - 1);
            cnt_q     <= '0;
            gap_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: doc/uart_msg_arbiter.md
Name: uart_msg_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single byte-wide debug UART transmitter between NUM_SRC independent message sources (status formatter, error reporter, frame-event logger).
- Each source presents a byte stream framed by a last flag. The arbiter locks the grant for a whole message so messages never interleave on the serial line.
- It enforces a minimum idle gap between messages and cuts off runaway messages with a length watchdog.
- Sits between the message formatters and the UART transmitter's byte-accept interface, all at 100 MHz.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- GAP_CYCLES, 16, idle clk cycles inserted after each message; 0 means no gap.
- MAX_PKT_LEN, 64, maximum bytes per message before forced termination (1..255).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  NUM_SRC  per-source byte valid.
- s_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
- s_last  in  NUM_SRC  per-source final byte of message, qualified by s_valid.
- s_ready  out  NUM_SRC  per-source byte accepted when s_valid & s_ready.
- m_valid  out  1  byte valid toward UART transmitter.
- m_data  out  8  byte toward UART transmitter.
- m_ready  in  1  UART transmitter can take byte.
- grant  out  NUM_SRC  one-hot current owner; all zero when not in XFER.
- busy  out  1  high in XFER or GAP.
- len_err  out  1  sticky: a message hit MAX_PKT_LEN without s_last.

Behaviour:
- Clocking and reset
  - Clock is clk.
  - Reset is reset: synchronous, active-high.
  - Reset values: state=IDLE, grant=0, s_ready=0, m_valid=0, m_data=0, busy=0, len_err=0, byte counter=0, gap counter=0, last-grant pointer=NUM_SRC-1 (source 0 wins first).
- States: IDLE, XFER, GAP.
- IDLE
  - m_valid=0 and all s_ready=0.
  - If any s_valid is high, the winner is the first valid index searching upward from (pointer+1) modulo NUM_SRC.
  - Next cycle: grant=onehot(winner), pointer=winner, byte counter=0, state=XFER.
  - Arbitration latency: 1 cycle from s_valid to grant.
- XFER
  - Combinational pass-through from the granted source g: m_valid=s_valid[g], m_data=s_data[g], s_ready[g]=m_ready. All other s_ready=0.
  - A handshake is m_valid & m_ready. Each handshake increments the 8-bit byte counter.
  - Handshake with s_last[g]=1: message ends.
  - Handshake without s_last where the counter reaches MAX_PKT_LEN: message is force-ended and len_err is set to 1.
  - Bytes of the cut-off message that arrive after the cutoff are treated as a new message from that source, subject to normal arbitration.
  - On message end: grant is cleared.
    - GAP_CYCLES>0: state=GAP, gap counter=GAP_CYCLES-1.
    - GAP_CYCLES=0: state=IDLE.
  - Source dropping s_valid mid-message: the grant stays held indefinitely and no other source is served.
- GAP
  - m_valid=0, all s_ready=0, busy=1.
  - Counter decrements each cycle. When the counter is 0, state=IDLE.
  - Gap length is exactly GAP_CYCLES cycles between the last handshake and return to IDLE.
- Simultaneous requests: round-robin order only. No fixed priority beyond the reset pointer.
- Pointer update: the pointer changes only on grant.
- Reset mid-message: aborts immediately. The partially sent message is not resumed, and the source must restart it.
- Combinational paths: m_data and m_valid are combinational from s_* through the grant mux. grant, busy and len_err are registered.

Test Plan:
- Single source: reset, source 1 sends 4-byte "AB\r\n" with last on the 4th byte, m_ready=1 → grant=3'b010 one cycle after s_valid. m_data sequence is 0x41,0x42,0x0D,0x0A. busy stays high 16 cycles after the last handshake, then IDLE.
- Contention: sources 0, 1 and 2 all hold 2-byte messages from the same cycle → grant order 0,1,2. No byte interleaving. 16-cycle gaps between messages.
- Fairness: source 0 continuously requests, source 2 requests once → after source 0's message, source 2 is granted before source 0 repeats.
- Backpressure: m_ready toggles 1,0,0,1 during a message → s_ready[g] mirrors m_ready. A byte is transferred only on m_ready=1, so 3 bytes take 3 m_ready-high cycles. Non-granted s_ready stays 0.
- Watchdog: source 2 streams 70 bytes with no s_last → exactly 64 bytes forwarded, then GAP, len_err=1 and held until reset. Remaining bytes are re-arbitrated as a new message.
- Reset mid-message: assert reset after byte 2 of a 5-byte message → next cycle m_valid=0, grant=0, len_err=0. The first grant after reset goes to source 0 when all sources request.
